// File: rtl/serial_mem_loader.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// serial_mem_loader
//
// UART-style frame receiver that writes one memory location per frame.
// A frame is: start bit (0), ADDR_W address bits LSB first, DATA_W data bits
// LSB first, [optional even-parity bit], stop bit (1). On a good frame the
// received address/data are presented on a/d and mw_ is pulsed low for
// MW_LEN clocks, followed by one recovery clock with mw_ high.
//
// Optional feature macro: SERIAL_MEM_LOADER_PARITY_EN
//   When defined, an even-parity bit (covering address and data) follows the
//   data field. A parity mismatch with a good stop bit pulses frame_err and
//   suppresses the write.
//
// Ports:
//   clock      in   system clock, all state on rising edge
//   reset      in   asynchronous active-high reset
//   rxd        in   serial line, idle high, asynchronous to clock
//   mw_        out  memory write strobe, active low
//   a          out  write address  (low ADDR_W bits of the receive buffer)
//   d          out  write data     (upper DATA_W bits of the receive buffer)
//   busy       out  high whenever the receiver is not idle
//   frame_err  out  one-clock pulse on a bad stop bit (or parity error)
// -----------------------------------------------------------------------------
module serial_mem_loader #(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 8,
  parameter int BIT_TICKS = 8,
  parameter int MW_LEN    = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rxd,
  output logic              mw_,
  output logic [ADDR_W-1:0] a,
  output logic [DATA_W-1:0] d,
  output logic              busy,
  output logic              frame_err
);

  localparam int BUF_W = ADDR_W + DATA_W;
`ifdef SERIAL_MEM_LOADER_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif
  // Number of sampled bits between start and stop.
  localparam int N       = BUF_W + PAR_W;
  localparam int WAIT_W  = $clog2(BIT_TICKS);
  localparam int COUNT_W = $clog2(N + 1);
  localparam int MW_W    = (MW_LEN > 1) ? $clog2(MW_LEN) : 1;

  localparam logic [WAIT_W-1:0]  HALF_LOAD  = WAIT_W'(BIT_TICKS / 2 - 1);
  localparam logic [WAIT_W-1:0]  FULL_LOAD  = WAIT_W'(BIT_TICKS - 1);
  localparam logic [COUNT_W-1:0] COUNT_LOAD = COUNT_W'(N);
  localparam logic [MW_W-1:0]    MW_LOAD    = MW_W'(MW_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_BITS,
    S_STOP,
    S_BREAK,
    S_WRITE,
    S_RECOVER
  } state_t;

  state_t               state_reg, state_next;
  logic [WAIT_W-1:0]    wait_reg, wait_next;
  logic [COUNT_W-1:0]   count_reg, count_next;
  logic [BUF_W-1:0]     buffer_reg, buffer_next;
  logic [MW_W-1:0]      mw_cnt_reg, mw_cnt_next;
  logic                 frame_err_reg, frame_err_next;
  logic                 mw_reg;
  logic                 busy_reg;
`ifdef SERIAL_MEM_LOADER_PARITY_EN
  logic                 parity_reg, parity_next;
`endif

  // Two-flop synchroniser; both stages reset to the idle (high) line level so
  // leaving reset never looks like a start bit.
  logic sync1_reg;
  logic rxs;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_reg <= 1'b1;
      rxs       <= 1'b1;
    end else begin
      sync1_reg <= rxd;
      rxs       <= sync1_reg;
    end
  end

  logic wait_zero;
  assign wait_zero = (wait_reg == '0);

  // State and datapath registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg     <= S_IDLE;
      wait_reg      <= '0;
      count_reg     <= '0;
      buffer_reg    <= '0;
      mw_cnt_reg    <= '0;
      frame_err_reg <= 1'b0;
      mw_reg        <= 1'b1;
      busy_reg      <= 1'b0;
`ifdef SERIAL_MEM_LOADER_PARITY_EN
      parity_reg    <= 1'b0;
`endif
    end else begin
      state_reg     <= state_next;
      wait_reg      <= wait_next;
      count_reg     <= count_next;
      buffer_reg    <= buffer_next;
      mw_cnt_reg    <= mw_cnt_next;
      frame_err_reg <= frame_err_next;
      // Strobes are registered from the next state so they are glitch-free
      // yet still line up exactly with the state they describe.
      mw_reg        <= (state_next != S_WRITE);
      busy_reg      <= (state_next != S_IDLE);
`ifdef SERIAL_MEM_LOADER_PARITY_EN
      parity_reg    <= parity_next;
`endif
    end
  end

  // Next-state and datapath logic.
  always_comb begin
    state_next     = state_reg;
    wait_next      = wait_reg;
    count_next     = count_reg;
    buffer_next    = buffer_reg;
    mw_cnt_next    = mw_cnt_reg;
    frame_err_next = 1'b0;
`ifdef SERIAL_MEM_LOADER_PARITY_EN
    parity_next    = parity_reg;
`endif

    case (state_reg)
      S_IDLE: begin
        if (!rxs) begin
          wait_next  = HALF_LOAD;
          state_next = S_START;
        end
      end

      S_START: begin
        if (wait_zero) begin
          // Mid-start-bit check: a line back high means it was a glitch.
          if (rxs) begin
            state_next = S_IDLE;
          end else begin
            wait_next  = FULL_LOAD;
            count_next = COUNT_LOAD;
            state_next = S_BITS;
          end
        end else begin
          wait_next = wait_reg - WAIT_W'(1);
        end
      end

      S_BITS: begin
        if (wait_zero) begin
          wait_next  = FULL_LOAD;
          count_next = count_reg - COUNT_W'(1);
`ifdef SERIAL_MEM_LOADER_PARITY_EN
          // The final sampled bit is parity; it is kept aside, not shifted.
          if (count_reg == COUNT_W'(1)) begin
            parity_next = rxs;
          end else begin
            buffer_next = {rxs, buffer_reg[BUF_W-1:1]};
          end
`else
          buffer_next = {rxs, buffer_reg[BUF_W-1:1]};
`endif
          if (count_reg == COUNT_W'(1)) begin
            state_next = S_STOP;
          end
        end else begin
          wait_next = wait_reg - WAIT_W'(1);
        end
      end

      S_STOP: begin
        if (wait_zero) begin
          if (rxs) begin
`ifdef SERIAL_MEM_LOADER_PARITY_EN
            if (parity_reg != (^buffer_reg)) begin
              frame_err_next = 1'b1;
              state_next     = S_IDLE;
            end else begin
              mw_cnt_next = MW_LOAD;
              state_next  = S_WRITE;
            end
`else
            mw_cnt_next = MW_LOAD;
            state_next  = S_WRITE;
`endif
          end else begin
            // Bad stop bit: keep the received bits but never write, and wait
            // for the line to return high so a stuck-low line cannot retrigger.
            frame_err_next = 1'b1;
            state_next     = S_BREAK;
          end
        end else begin
          wait_next = wait_reg - WAIT_W'(1);
        end
      end

      S_BREAK: begin
        if (rxs) begin
          state_next = S_IDLE;
        end
      end

      S_WRITE: begin
        if (mw_cnt_reg == '0) begin
          state_next = S_RECOVER;
        end else begin
          mw_cnt_next = mw_cnt_reg - MW_W'(1);
        end
      end

      S_RECOVER: begin
        state_next = S_IDLE;
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign mw_       = mw_reg;
  assign busy      = busy_reg;
  assign frame_err = frame_err_reg;
  assign a         = buffer_reg[ADDR_W-1:0];
  assign d         = buffer_reg[BUF_W-1:ADDR_W];

endmodule

// File: tb/tb_serial_mem_loader.sv
`timescale 1ns/1ps
module tb_serial_mem_loader;

  localparam int AW = 10;
  localparam int DW = 8;
`ifdef SERIAL_MEM_LOADER_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int NB = AW + DW + PAR;
  localparam int B0 = 8;
  localparam int B1 = 16;
  localparam int M0 = 1;
  localparam int M1 = 3;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          rxd      [2];
  logic          mw_n     [2];
  logic [AW-1:0] a_o      [2];
  logic [DW-1:0] d_o      [2];
  logic          busy_o   [2];
  logic          fe_o     [2];

  serial_mem_loader #(.ADDR_W(AW), .DATA_W(DW), .BIT_TICKS(B0), .MW_LEN(M0)) dut0 (
    .clock(clock), .reset(reset), .rxd(rxd[0]), .mw_(mw_n[0]),
    .a(a_o[0]), .d(d_o[0]), .busy(busy_o[0]), .frame_err(fe_o[0])
  );

  serial_mem_loader #(.ADDR_W(AW), .DATA_W(DW), .BIT_TICKS(B1), .MW_LEN(M1)) dut1 (
    .clock(clock), .reset(reset), .rxd(rxd[1]), .mw_(mw_n[1]),
    .a(a_o[1]), .d(d_o[1]), .busy(busy_o[1]), .frame_err(fe_o[1])
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s dut%0d: got 0x%0h expected 0x%0h (cycle %0d)", name, k, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model: expected events per DUT ----------------
  int            wr_fall [2][32];
  logic [AW-1:0] wr_a    [2][32];
  logic [DW-1:0] wr_d    [2][32];
  int            wr_head [2] = '{0, 0};
  int            wr_tail [2] = '{0, 0};
  int            fe_cyc  [2][32];
  int            fe_head [2] = '{0, 0};
  int            fe_tail [2] = '{0, 0};
  int            writes_seen [2] = '{0, 0};

  function automatic int bt(input int k);
    return (k == 0) ? B0 : B1;
  endfunction

  function automatic int mwl(input int k);
    return (k == 0) ? M0 : M1;
  endfunction

  // rxd falls at a negedge with cyc==start; two synchroniser edges later the
  // receiver sees it on the third edge and leaves IDLE. The stop sample is
  // BIT_TICKS/2 + (N+1)*BIT_TICKS edges after that; mw_/frame_err react on it.
  function automatic int stop_sample_cyc(input int k, input int start);
    return start + 3 + bt(k) / 2 + (NB + 1) * bt(k);
  endfunction

  // Sends one frame on rxd[k]; the model expectation is recorded up front.
  // abort_at >= 0 asserts reset in the middle of that frame bit instead.
  task automatic send_frame(input int k, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                            input logic stop, input logic bad_par, input int abort_at);
    logic fb [0:NB+1];
    int   b     = bt(k);
    int   start = cyc;
    fb[0] = 1'b0;
    for (int i = 0; i < AW; i++) fb[1 + i] = addr[i];
    for (int i = 0; i < DW; i++) fb[1 + AW + i] = data[i];
`ifdef SERIAL_MEM_LOADER_PARITY_EN
    fb[1 + AW + DW] = (^{data, addr}) ^ bad_par;
`endif
    fb[NB + 1] = stop;
    if (abort_at < 0) begin
      if (stop && !bad_par) begin
        wr_fall[k][wr_tail[k]] = stop_sample_cyc(k, start);
        wr_a[k][wr_tail[k]]    = addr;
        wr_d[k][wr_tail[k]]    = data;
        wr_tail[k]++;
      end else begin
        fe_cyc[k][fe_tail[k]] = stop_sample_cyc(k, start);
        fe_tail[k]++;
      end
    end
    for (int i = 0; i <= NB + 1; i++) begin
      rxd[k] = fb[i];
      if (i == abort_at) begin
        repeat (b / 2) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        check("abort_mw_", k, 32'(mw_n[k]), 32'd1);
        check("abort_busy", k, 32'(busy_o[k]), 32'd0);
        check("abort_a", k, 32'(a_o[k]), 32'd0);
        check("abort_d", k, 32'(d_o[k]), 32'd0);
        rxd[k] = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        return;
      end
      repeat (b) @(negedge clock);
    end
  endtask

  // ---------------- compare process ----------------
  logic          in_pulse [2] = '{1'b0, 1'b0};
  int            width    [2] = '{0, 0};
  logic [AW-1:0] cur_a [2];
  logic [DW-1:0] cur_d [2];
  logic [AW-1:0] prev_a [2];
  logic [DW-1:0] prev_d [2];

  always @(negedge clock) begin
    if (!reset) begin
      for (int k = 0; k < 2; k++) begin
        if (fe_o[k]) begin
          if (fe_head[k] == fe_tail[k]) begin
            check("frame_err_unexpected", k, 32'd1, 32'd0);
          end else begin
            check("frame_err_cycle", k, 32'(cyc), 32'(fe_cyc[k][fe_head[k]]));
            fe_head[k]++;
          end
        end else if (fe_head[k] != fe_tail[k] && fe_cyc[k][fe_head[k]] < cyc) begin
          check("frame_err_missing", k, 32'd0, 32'd1);
          fe_head[k]++;
        end

        if (!mw_n[k]) begin
          if (!in_pulse[k]) begin
            if (wr_head[k] == wr_tail[k]) begin
              check("mw_unexpected", k, 32'd1, 32'd0);
              cur_a[k] = a_o[k];
              cur_d[k] = d_o[k];
            end else begin
              check("mw_fall_cycle", k, 32'(cyc), 32'(wr_fall[k][wr_head[k]]));
              check("a_at_fall", k, 32'(a_o[k]), 32'(wr_a[k][wr_head[k]]));
              check("d_at_fall", k, 32'(d_o[k]), 32'(wr_d[k][wr_head[k]]));
              check("a_setup", k, 32'(prev_a[k]), 32'(wr_a[k][wr_head[k]]));
              check("d_setup", k, 32'(prev_d[k]), 32'(wr_d[k][wr_head[k]]));
              cur_a[k] = wr_a[k][wr_head[k]];
              cur_d[k] = wr_d[k][wr_head[k]];
              wr_head[k]++;
            end
            in_pulse[k] = 1'b1;
            width[k]    = 1;
            writes_seen[k]++;
          end else begin
            width[k]++;
            check("a_during", k, 32'(a_o[k]), 32'(cur_a[k]));
            check("d_during", k, 32'(d_o[k]), 32'(cur_d[k]));
          end
        end else begin
          if (in_pulse[k]) begin
            check("mw_width", k, 32'(width[k]), 32'(mwl(k)));
            check("a_hold", k, 32'(a_o[k]), 32'(cur_a[k]));
            check("d_hold", k, 32'(d_o[k]), 32'(cur_d[k]));
            in_pulse[k] = 1'b0;
          end
          if (wr_head[k] != wr_tail[k] && wr_fall[k][wr_head[k]] < cyc) begin
            check("mw_missing", k, 32'd0, 32'd1);
            wr_head[k]++;
          end
        end
        prev_a[k] = a_o[k];
        prev_d[k] = d_o[k];
      end
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int busy_cnt;
    rxd[0] = 1'b1;
    rxd[1] = 1'b1;
    reset  = 1'b1;
    repeat (3) @(negedge clock);
    for (int k = 0; k < 2; k++) begin
      check("reset_mw_", k, 32'(mw_n[k]), 32'd1);
      check("reset_busy", k, 32'(busy_o[k]), 32'd0);
      check("reset_a", k, 32'(a_o[k]), 32'd0);
      check("reset_d", k, 32'(d_o[k]), 32'd0);
      check("reset_frame_err", k, 32'(fe_o[k]), 32'd0);
    end
    reset = 1'b0;
    repeat (4) @(negedge clock);

    // 1: basic write; one clock of RECOVER after the strobe, then idle.
    send_frame(0, 10'h2A5, 8'h3C, 1'b1, 1'b0, -1);
    rxd[0] = 1'b1;
    check("busy_in_recover", 0, 32'(busy_o[0]), 32'd1);
    @(negedge clock);
    check("busy_after_recover", 0, 32'(busy_o[0]), 32'd0);
    check("t1_a", 0, 32'(a_o[0]), 32'h2A5);
    check("t1_d", 0, 32'(d_o[0]), 32'h3C);
    repeat (4) @(negedge clock);

    // 2: two-clock glitch is rejected after half a bit time.
    rxd[0] = 1'b0;
    repeat (2) @(negedge clock);
    rxd[0] = 1'b1;
    busy_cnt = 0;
    repeat (20) begin
      if (busy_o[0]) busy_cnt++;
      @(negedge clock);
    end
    check("glitch_busy_clocks", 0, 32'(busy_cnt), 32'd4);
    check("glitch_a_kept", 0, 32'(a_o[0]), 32'h2A5);
    check("glitch_d_kept", 0, 32'(d_o[0]), 32'h3C);

    // 3: bad stop bit, line held low; busy until the line recovers.
    send_frame(0, 10'h001, 8'hFF, 1'b0, 1'b0, -1);
    repeat (40) @(negedge clock);
    check("busy_in_break", 0, 32'(busy_o[0]), 32'd1);
    check("break_a", 0, 32'(a_o[0]), 32'h001);
    check("break_d", 0, 32'(d_o[0]), 32'hFF);
    rxd[0] = 1'b1;
    repeat (2) @(negedge clock);
    check("busy_line_sync", 0, 32'(busy_o[0]), 32'd1);
    repeat (2) @(negedge clock);
    check("busy_break_exit", 0, 32'(busy_o[0]), 32'd0);
    repeat (4) @(negedge clock);

    // 4: reset during payload bit 9, then a clean frame.
    send_frame(0, 10'h0F0, 8'h5A, 1'b1, 1'b0, 10);
    repeat (4) @(negedge clock);
    send_frame(0, 10'h155, 8'hAA, 1'b1, 1'b0, -1);
    rxd[0] = 1'b1;
    repeat (4) @(negedge clock);
    check("t4_a", 0, 32'(a_o[0]), 32'h155);
    check("t4_d", 0, 32'(d_o[0]), 32'hAA);

    // 5: slow, long-strobe instance with back-to-back frames.
    send_frame(1, 10'h3FF, 8'h00, 1'b1, 1'b0, -1);
    rxd[1] = 1'b1;
    repeat (5) @(negedge clock);
    send_frame(1, 10'h000, 8'h81, 1'b1, 1'b0, -1);
    rxd[1] = 1'b1;
    repeat (30) @(negedge clock);
    check("t5_a", 1, 32'(a_o[1]), 32'h000);
    check("t5_d", 1, 32'(d_o[1]), 32'h81);

`ifdef SERIAL_MEM_LOADER_PARITY_EN
    // 6: wrong parity rejected, correct parity written.
    send_frame(0, 10'h2A5, 8'h3C, 1'b1, 1'b1, -1);
    rxd[0] = 1'b1;
    repeat (4) @(negedge clock);
    send_frame(0, 10'h2A5, 8'h3C, 1'b1, 1'b0, -1);
    rxd[0] = 1'b1;
    repeat (4) @(negedge clock);
`endif

    repeat (10) @(negedge clock);
    for (int k = 0; k < 2; k++) begin
      check("writes_pending", k, 32'(wr_tail[k] - wr_head[k]), 32'd0);
      check("frame_err_pending", k, 32'(fe_tail[k] - fe_head[k]), 32'd0);
    end
    check("write_count", 0, 32'(writes_seen[0]), 32'(2 + PAR));
    check("write_count", 1, 32'(writes_seen[1]), 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/serial_mem_loader.md
Name: serial_mem_loader

Overview:
- Parametrised UART-style frame receiver that loads one memory location per frame.
- Each frame carries an address field followed by a data field, LSB first.
- On a valid frame the block drives address and data and pulses active-low mw_ for a configurable number of clocks.
- Sits between the serial line and a single-port RAM write port. Adds glitch rejection, stop-bit checking, a busy flag and a defined reset state for the buffer.

Parameters:
- ADDR_W, 10, address field width in bits (1..16).
- DATA_W, 8, data field width in bits (1..16).
- BIT_TICKS, 8, clocks per serial bit; must be even and >=4.
- MW_LEN, 1, clocks mw_ is held low per write (1..8).

Ports:
- clock  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- rxd  in  1  serial line, idle high, asynchronous to clock.
- mw_  out  1  memory write strobe, active low.
- a  out  ADDR_W  write address = BUFFER[ADDR_W-1:0].
- d  out  DATA_W  write data = BUFFER[ADDR_W+DATA_W-1:ADDR_W].
- busy  out  1  high in any state other than IDLE.
- frame_err  out  1  one-clock pulse on bad stop bit (or parity error, see option).

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values:
  - mw_=1, frame_err=0, busy=0.
  - BUFFER=0, so a=0 and d=0.
  - Both synchroniser flops =1; state=IDLE.
- Synchroniser: rxd passes through 2 flops to rxs; only rxs is used internally.
- Frame length: N = ADDR_W+DATA_W payload bits (+1 parity with option), plus start and stop bits.
- BUFFER: ADDR_W+DATA_W bits wide, shifted right. The new bit enters the MSB, so the first payload bit ends in BUFFER[0].
- IDLE:
  - If rxs==0, load WAIT=BIT_TICKS/2-1 and go START.
- START:
  - Decrement WAIT each clock.
  - At WAIT==0, sample rxs. If 1, the event is a glitch: return to IDLE with no other effect.
  - If 0, load WAIT=BIT_TICKS-1 and COUNT=N, then go BITS.
- BITS:
  - Decrement WAIT each clock.
  - At WAIT==0, shift rxs into BUFFER, COUNT<=COUNT-1, WAIT<=BIT_TICKS-1.
  - If COUNT==1, go STOP; otherwise stay in BITS.
  - Sample i (i=1..N) falls BIT_TICKS/2 + i*BIT_TICKS clocks after leaving IDLE, i.e. at mid-bit.
- STOP:
  - Decrement WAIT each clock.
  - At WAIT==0, if rxs==1, load MW count and go WRITE.
  - If rxs==0, pulse frame_err for 1 clock and go BREAK. No write occurs and BUFFER keeps the received bits.
- BREAK:
  - Wait for rxs==1, then go IDLE.
  - A line held low never triggers a write.
- WRITE:
  - mw_=0 for exactly MW_LEN clocks.
  - mw_ falls in the clock after the stop-bit sample.
  - a and d are stable from one clock before mw_ falls until one clock after mw_ rises.
- RECOVER:
  - mw_=1 for 1 clock, then go IDLE.
- rxd during WRITE/RECOVER: ignored. A start bit arriving there is caught by its low level on IDLE entry (timing then skewed). Senders must leave at least MW_LEN+2 clocks of idle between frames.
- Reset mid-operation: all state returns to reset values immediately. A mw_ pulse in progress is cut short (mw_ goes 1 asynchronously).
- Counter widths: WAIT is clog2(BIT_TICKS) bits; COUNT is clog2(N+1) bits. No wrap occurs in legal operation.

Optional Feature:
- Macro: SERIAL_MEM_LOADER_PARITY_EN.
- Defined:
  - One even-parity bit follows the data field, sampled like payload bits but not stored in BUFFER. N includes it.
  - In STOP, a parity mismatch with a valid stop bit pulses frame_err 1 clock, skips WRITE and goes IDLE.
- Undefined: no parity bit; the frame is exactly start + ADDR_W+DATA_W + stop.

Test Plan:
1. Defaults, frame a=0x2A5, d=0x3C, valid stop -> one mw_ low pulse of 1 clock; a=0x2A5, d=0x3C during the pulse; frame_err stays 0; busy falls after RECOVER.
2. rxd low for 2 clocks, then high -> START rejects it; busy high for BIT_TICKS/2 clocks; no mw_; BUFFER unchanged.
3. Frame a=0x001, d=0xFF with stop bit 0 and line held low 40 clocks -> frame_err 1-clock pulse at stop sample; no mw_; busy stays high until rxd returns high.
4. Reset asserted at payload bit 9 of a frame -> mw_=1, busy=0, a=0, d=0 immediately; the next full frame a=0x155, d=0xAA writes correctly.
5. MW_LEN=3, BIT_TICKS=16, two back-to-back frames with a 5-clock gap (a=0x3FF/d=0x00, then a=0x000/d=0x81) -> two mw_ pulses of 3 clocks each with correct a/d.
6. PARITY_EN, frame a=0x2A5, d=0x3C with wrong parity -> frame_err pulse, no mw_. Same frame with correct parity -> write occurs.
